// File: rtl/div_repsub_pkg.sv
// Shared constants for the repeated-subtraction divider: default operand
// width and FSM state encodings.
package div_repsub_pkg;

  // Default operand width in bits.
  localparam int unsigned DIV_SIZE_DEFAULT = 8;

  // FSM encoding; 2'd3 is illegal and recovers to ST_IDLE.
  typedef logic [1:0] div_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage : div_repsub_pkg

// File: rtl/div_repsub.sv
// Unsigned divider using repeated subtraction, one subtraction per clock.
// A start pulse in IDLE latches the operands. When the division finishes,
// quotient and remainder are presented with a one-cycle done pulse.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        request a division (sampled only in IDLE)
//   dividend     unsigned dividend, sampled with start
//   divisor      unsigned divisor, sampled with start
//   busy         high whenever the FSM is not in IDLE
//   done         one-cycle result-valid pulse
//   div_by_zero  qualifies done: the latched divisor was zero
//   quotient     registered quotient (all ones on divide by zero)
//   remainder    registered remainder (dividend on divide by zero)
module div_repsub
  import div_repsub_pkg::*;
#(
  parameter int unsigned size = DIV_SIZE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] dividend,
  input  logic [size-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [size-1:0] quotient,
  output logic [size-1:0] remainder
);

  div_state_t      state, state_nxt;
  logic [size-1:0] div_r, div_nxt;
  logic [size-1:0] rem_r, rem_nxt;
  logic [size-1:0] quo_r, quo_nxt;
  logic            done_nxt;
  logic            dbz_nxt;
  logic [size-1:0] quot_nxt;
  logic [size-1:0] remd_nxt;

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      div_r       <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      state       <= state_nxt;
      div_r       <= div_nxt;
      rem_r       <= rem_nxt;
      quo_r       <= quo_nxt;
      // busy is registered from the next state so it tracks state != IDLE.
      busy        <= (state_nxt != ST_IDLE);
      done        <= done_nxt;
      div_by_zero <= dbz_nxt;
      quotient    <= quot_nxt;
      remainder   <= remd_nxt;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_r;
    rem_nxt   = rem_r;
    quo_nxt   = quo_r;
    done_nxt  = 1'b0;
    dbz_nxt   = div_by_zero;
    quot_nxt  = quotient;
    remd_nxt  = remainder;

    case (state)
      ST_IDLE: begin
        if (start) begin
          div_nxt = divisor;
          rem_nxt = dividend;
          quo_nxt = '0;
          if (divisor == '0) begin
            // Divide by zero skips RUN and reports immediately.
            state_nxt = ST_DONE;
            quot_nxt  = '1;
            remd_nxt  = dividend;
            dbz_nxt   = 1'b1;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        // The compare guards the subtract, so rem_r cannot underflow.
        if (rem_r >= div_r) begin
          rem_nxt = rem_r - div_r;
          quo_nxt = quo_r + size'(1);
        end else begin
          state_nxt = ST_DONE;
          quot_nxt  = quo_r;
          remd_nxt  = rem_r;
          dbz_nxt   = 1'b0;
          done_nxt  = 1'b1;
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule : div_repsub
